// File: rtl/crc_pkg.sv
// Shared CRC constants and bit-serial helpers for the streaming CRC engine.
// The helpers are pure functions so the parallel update unrolls into XOR trees.
package crc_pkg;

  localparam int          CRC_WIDTH         = 32;
  localparam logic [31:0] CRC32_ETH_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_ETH_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Reflected mode shifts right with the mirrored polynomial, consuming bit 0 first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                           input logic [7:0]  data_byte,
                                           input logic [31:0] poly,
                                           input logic        reflect);
    logic [31:0] c;
    logic [31:0] rpoly;
    logic        fb;
    c     = crc;
    rpoly = reflect32(poly);
    for (int i = 0; i < 8; i++) begin
      if (reflect) begin
        fb = c[0] ^ data_byte[i];
        c  = c >> 1;
        if (fb) c = c ^ rpoly;
      end else begin
        fb = c[31] ^ data_byte[7-i];
        c  = c << 1;
        if (fb) c = c ^ poly;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_par_update.sv
// Combinational multi-byte CRC update: chains DATA_BYTES byte steps and
// selects the intermediate register after the first n bytes.
module crc_par_update
  import crc_pkg::*;
#(
  parameter int          DATA_BYTES = 8,
  parameter logic [31:0] POLY       = CRC32_ETH_POLY,
  parameter bit          REFLECT    = 1'b1,
  localparam int         NW         = $clog2(DATA_BYTES + 1)
) (
  input  logic [CRC_WIDTH-1:0]    crc_in,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [NW-1:0]           n,
  output logic [CRC_WIDTH-1:0]    crc_out
);

  logic [CRC_WIDTH-1:0] stage [DATA_BYTES+1];

  always_comb begin
    stage[0] = crc_in;
    for (int i = 0; i < DATA_BYTES; i++) begin
      stage[i+1] = crc_byte(stage[i], data[8*i +: 8], POLY, REFLECT);
    end
    crc_out = crc_in;
    for (int i = 0; i <= DATA_BYTES; i++) begin
      if (n == NW'(i)) crc_out = stage[i];
    end
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC generator/checker: valid/ready byte beats in, one registered
// result per frame out (FCS in GEN mode, residue pass/fail in CHECK mode).
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int          DATA_BYTES  = 8,
  parameter logic [31:0] POLY        = CRC32_ETH_POLY,
  parameter logic [31:0] INITIAL_CRC = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT     = 32'hFFFFFFFF,
  parameter bit          REFLECT     = 1'b1,
  parameter logic [31:0] RESIDUE     = CRC32_ETH_RESIDUE,
  parameter int          LEN_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [DATA_BYTES-1:0]   in_keep,
  input  logic                    in_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_crc,
  output logic                    res_ok,
  output logic [LEN_WIDTH-1:0]    res_len,
  output logic                    res_keep_err
);

  localparam int NW = $clog2(DATA_BYTES + 1);

  logic [31:0]          crc_q, crc_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 in_frame_q, in_frame_d;
  logic                 mode_q, mode_d;
  logic                 keep_err_q, keep_err_d;
  logic                 res_valid_q, res_valid_d;
  logic [31:0]          res_crc_q, res_crc_d;
  logic                 res_ok_q, res_ok_d;
  logic [LEN_WIDTH-1:0] res_len_q, res_len_d;
  logic                 res_keep_err_q, res_keep_err_d;

  logic [NW-1:0]        n;
  logic                 run;
  logic                 beat_kerr;
  logic                 accept;
  logic                 mode_eff;
  logic [31:0]          crc_upd;
  logic [LEN_WIDTH:0]   len_sum;
  logic [LEN_WIDTH-1:0] len_new;

  crc_par_update #(
    .DATA_BYTES (DATA_BYTES),
    .POLY       (POLY),
    .REFLECT    (REFLECT)
  ) u_update (
    .crc_in  (crc_q),
    .data    (in_data),
    .n       (n),
    .crc_out (crc_upd)
  );

  // Only the leading run of keep bits counts; anything set past a hole flags an error.
  always_comb begin
    n         = '0;
    run       = 1'b1;
    beat_kerr = 1'b0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (in_keep[i] && run) n = NW'(i + 1);
      else if (in_keep[i])   beat_kerr = 1'b1;
      else                   run = 1'b0;
    end
  end

  assign in_ready = !(res_valid_q && !res_ready);
  assign accept   = in_valid && in_ready;
  assign mode_eff = in_frame_q ? mode_q : mode;
  assign len_sum  = {1'b0, len_q} + {{(LEN_WIDTH + 1 - NW){1'b0}}, n};
  assign len_new  = len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];

  always_comb begin
    crc_d          = crc_q;
    len_d          = len_q;
    in_frame_d     = in_frame_q;
    mode_d         = mode_q;
    keep_err_d     = keep_err_q;
    res_valid_d    = res_valid_q && !res_ready;
    res_crc_d      = res_crc_q;
    res_ok_d       = res_ok_q;
    res_len_d      = res_len_q;
    res_keep_err_d = res_keep_err_q;

    if (flush) begin
      crc_d      = INITIAL_CRC;
      len_d      = '0;
      in_frame_d = 1'b0;
      keep_err_d = 1'b0;
    end else if (accept) begin
      if (in_last) begin
        res_valid_d    = 1'b1;
        res_crc_d      = crc_upd ^ XOR_OUT;
        res_ok_d       = mode_eff ? (crc_upd == RESIDUE) : 1'b1;
        res_len_d      = len_new;
        res_keep_err_d = keep_err_q | beat_kerr;
        crc_d          = INITIAL_CRC;
        len_d          = '0;
        in_frame_d     = 1'b0;
        keep_err_d     = 1'b0;
      end else begin
        crc_d      = crc_upd;
        len_d      = len_new;
        keep_err_d = keep_err_q | beat_kerr;
        if (!in_frame_q) begin
          mode_d     = mode;
          in_frame_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q          <= INITIAL_CRC;
      len_q          <= '0;
      in_frame_q     <= 1'b0;
      mode_q         <= 1'b0;
      keep_err_q     <= 1'b0;
      res_valid_q    <= 1'b0;
      res_crc_q      <= '0;
      res_ok_q       <= 1'b0;
      res_len_q      <= '0;
      res_keep_err_q <= 1'b0;
    end else begin
      crc_q          <= crc_d;
      len_q          <= len_d;
      in_frame_q     <= in_frame_d;
      mode_q         <= mode_d;
      keep_err_q     <= keep_err_d;
      res_valid_q    <= res_valid_d;
      res_crc_q      <= res_crc_d;
      res_ok_q       <= res_ok_d;
      res_len_q      <= res_len_d;
      res_keep_err_q <= res_keep_err_d;
    end
  end

  assign res_valid    = res_valid_q;
  assign res_crc      = res_crc_q;
  assign res_ok       = res_ok_q;
  assign res_len      = res_len_q;
  assign res_keep_err = res_keep_err_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed bench for crc_stream_engine with Ethernet CRC-32 defaults, 8 bytes/beat.
module tb_crc_stream_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [7:0]  in_keep = '0;
  logic        in_last = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_crc;
  logic        res_ok;
  logic [15:0] res_len;
  logic        res_keep_err;

  int errors = 0;
  int checks = 0;

  crc_stream_engine #(.DATA_BYTES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode         (mode),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_keep      (in_keep),
    .in_last      (in_last),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_crc      (res_crc),
    .res_ok       (res_ok),
    .res_len      (res_len),
    .res_keep_err (res_keep_err)
  );

  always #5 clk = ~clk;

  // "12345678" packed byte 0 first, then "9" plus FCS 26 39 F4 CB.
  localparam logic [63:0] STR_LO  = 64'h3837363534333231;
  localparam logic [63:0] STR_HI  = 64'h0000000000000039;
  localparam logic [63:0] STR_FCS = 64'h000000CBF4392639;

  // Presents one beat, waits (bounded) for in_ready, returns #1 after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic l, input logic m);
    int guard;
    guard    = 0;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    mode     = m;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout in_ready=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (res_valid !== 1'b0 || res_crc !== 32'h0 || res_ok !== 1'b0 ||
        res_len !== 16'h0 || res_keep_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b crc=%h ok=%b len=%0d ke=%b want all zero",
               res_valid, res_crc, res_ok, res_len, res_keep_err);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_gen();
    send_beat(STR_LO, 8'hFF, 1'b0, 1'b0);
    send_beat(STR_HI, 8'h01, 1'b1, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || res_crc !== 32'hCBF43926) begin
      errors++;
      $display("FAIL gen_crc got v=%b crc=%h want v=1 crc=cbf43926", res_valid, res_crc);
    end
    checks++;
    if (res_len !== 16'd9 || res_ok !== 1'b1 || res_keep_err !== 1'b0) begin
      errors++;
      $display("FAIL gen_meta got len=%0d ok=%b ke=%b want len=9 ok=1 ke=0",
               res_len, res_ok, res_keep_err);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL gen_consumed res_valid=%b want=0", res_valid);
    end
  endtask

  task automatic test_check();
    // mode only counts on the first beat of a multi-beat frame
    send_beat(STR_LO, 8'hFF, 1'b0, 1'b1);
    send_beat(STR_FCS, 8'h1F, 1'b1, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || res_ok !== 1'b1 || res_len !== 16'd13) begin
      errors++;
      $display("FAIL check_good got v=%b ok=%b len=%0d want v=1 ok=1 len=13",
               res_valid, res_ok, res_len);
    end
    send_beat(STR_LO ^ 64'h1, 8'hFF, 1'b0, 1'b1);
    send_beat(STR_FCS, 8'h1F, 1'b1, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || res_ok !== 1'b0) begin
      errors++;
      $display("FAIL check_corrupt got v=%b ok=%b want v=1 ok=0", res_valid, res_ok);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    res_ready = 1'b0;
    send_beat(64'h61, 8'h01, 1'b1, 1'b0);
    in_data  = 64'h636261;
    in_keep  = 8'h07;
    in_last  = 1'b1;
    mode     = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || res_valid !== 1'b1 || res_crc !== 32'hE8B7BE43 || res_len !== 16'd1) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b v=%b crc=%h len=%0d want rdy=0 v=1 crc=e8b7be43 len=1",
                 c, in_ready, res_valid, res_crc, res_len);
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release in_ready=%b want=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (res_valid !== 1'b1 || res_crc !== 32'h352441C2 || res_len !== 16'd3) begin
      errors++;
      $display("FAIL bp_second got v=%b crc=%h len=%0d want v=1 crc=352441c2 len=3",
               res_valid, res_crc, res_len);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain res_valid=%b want=0", res_valid);
    end
  endtask

  task automatic test_keep();
    send_beat(64'h63FF6261, 8'b0000_1011, 1'b1, 1'b0);
    checks++;
    if (res_crc !== 32'h9E83486D || res_len !== 16'd2 || res_keep_err !== 1'b1) begin
      errors++;
      $display("FAIL keep_hole got crc=%h len=%0d ke=%b want crc=9e83486d len=2 ke=1",
               res_crc, res_len, res_keep_err);
    end
    // empty non-last beat is consumed without touching the CRC
    send_beat(64'hFFFF, 8'h00, 1'b0, 1'b0);
    send_beat(64'h61, 8'h01, 1'b1, 1'b0);
    checks++;
    if (res_crc !== 32'hE8B7BE43 || res_len !== 16'd1 || res_keep_err !== 1'b0) begin
      errors++;
      $display("FAIL keep_zero_beat got crc=%h len=%0d ke=%b want crc=e8b7be43 len=1 ke=0",
               res_crc, res_len, res_keep_err);
    end
  endtask

  task automatic test_empty_flush();
    send_beat(64'h0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || res_crc !== 32'h0 || res_len !== 16'd0) begin
      errors++;
      $display("FAIL empty_frame got v=%b crc=%h len=%0d want v=1 crc=0 len=0",
               res_valid, res_crc, res_len);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    send_beat(64'h61, 8'h01, 1'b1, 1'b0);
    flush = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL flush_last res_valid=%b want=0", res_valid);
    end
    send_beat(STR_LO, 8'hFF, 1'b0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    send_beat(64'h61, 8'h01, 1'b1, 1'b0);
    checks++;
    if (res_crc !== 32'hE8B7BE43 || res_len !== 16'd1) begin
      errors++;
      $display("FAIL flush_midframe got crc=%h len=%0d want crc=e8b7be43 len=1", res_crc, res_len);
    end
  endtask

  task automatic test_reset_midframe();
    @(posedge clk); #1;
    send_beat(STR_LO, 8'hFF, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_crc !== 32'h0 || res_len !== 16'h0 || res_ok !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got v=%b crc=%h len=%0d ok=%b want all zero",
               res_valid, res_crc, res_len, res_ok);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(STR_LO, 8'hFF, 1'b0, 1'b0);
    send_beat(STR_HI, 8'h01, 1'b1, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || res_crc !== 32'hCBF43926 || res_len !== 16'd9) begin
      errors++;
      $display("FAIL reset_recover got v=%b crc=%h len=%0d want v=1 crc=cbf43926 len=9",
               res_valid, res_crc, res_len);
    end
  endtask

  initial begin
    test_reset();
    test_gen();
    test_check();
    test_back_to_back();
    test_keep();
    test_empty_flush();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised, streaming successor to the team's table-driven CRC-32 slice block.
- Consumes a valid/ready byte stream of DATA_BYTES per beat with per-byte keep and frame delimiting. Computes the CRC of each frame without lookup-table memories, using a polynomial-parameterised unrolled update.
- Reports one registered result per frame: either the generated FCS (GEN mode) or a residue pass/fail (CHECK mode).
- Sits between MAC TX/RX framing and the 64-bit PCS datapath.

Parameters:
- DATA_BYTES, 8, bytes per beat (1..16).
- POLY, 32'h04C11DB7, generator polynomial, normal form.
- INITIAL_CRC, 32'hFFFFFFFF, register value at start of each frame.
- XOR_OUT, 32'hFFFFFFFF, XORed into the register to form res_crc.
- REFLECT, 1, 1 = LSB-first bytes and reflected register (Ethernet); 0 = MSB-first.
- RESIDUE, 32'hDEBB20E3, expected raw register value after data+FCS in CHECK mode.
- LEN_WIDTH, 16, width of the frame byte counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = GEN, 1 = CHECK; sampled on the first accepted beat of a frame.
- flush  in  1  synchronous abort of the current frame.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accept.
- in_data  in  8*DATA_BYTES  byte i at [8i+:8]; byte 0 is first on the wire.
- in_keep  in  DATA_BYTES  byte enables.
- in_last  in  1  final beat of the frame.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_crc  out  32  final CRC (register ^ XOR_OUT).
- res_ok  out  1  CHECK: register == RESIDUE; GEN: 1.
- res_len  out  LEN_WIDTH  frame byte count, saturating.
- res_keep_err  out  1  a non-contiguous keep was seen in the frame.

Behaviour:
- Reset (rst_n low, async): crc_reg = INITIAL_CRC; in_frame = 0; len = 0; mode_q = 0; keep_err = 0; res_valid = 0; res_crc = 0; res_ok = 0; res_len = 0; res_keep_err = 0.
- Reset mid-frame abandons the frame; no result is produced.
- in_ready = !(res_valid && !res_ready). Stalls only while an unconsumed result is held; combinational from res_valid/res_ready only, never from in_valid.
- Accept = in_valid && in_ready.
- Byte count n = number of contiguous ones in in_keep from bit 0.
  - Keep bits above the first zero are ignored.
  - If any are set, keep_err is set (sticky within the frame).
- On an accepted non-last beat:
  - crc_reg <= update(crc_reg, first n bytes).
  - len <= len + n, saturating at all-ones.
  - If !in_frame: mode_q <= mode and in_frame <= 1.
- n = 0 on a non-last beat: crc_reg and len are unchanged; the beat is still consumed.
- On an accepted last beat, the cycle after acceptance (1-cycle latency):
  - res_valid = 1.
  - res_crc = update(...) ^ XOR_OUT.
  - res_ok = (mode_eff ? update(...) == RESIDUE : 1), where mode_eff = in_frame ? mode_q : mode.
  - res_len = final len; res_keep_err = final flag.
  - crc_reg, len, keep_err and in_frame return to their initial values.
  - A single-beat frame (first and last together) uses the live mode.
- Last beat with n = 0: the result reflects the prior bytes only. An empty frame yields res_crc = INITIAL_CRC ^ XOR_OUT = 0 with the defaults.
- Result outputs are held stable while res_valid && !res_ready.
  - res_valid clears on res_ready unless a new last beat is accepted in the same cycle.
  - On res_ready with a same-cycle last-beat accept, the new result loads: back-to-back frames at one per cycle.
- flush: crc_reg, len, keep_err and in_frame return to their initial values.
  - A beat accepted in the same cycle is discarded, including a last beat: no result.
  - A held result is unaffected.
- update():
  - Serial LFSR semantics applied byte 0 first.
  - REFLECT = 1: each byte LSB-first, right-shifting register using the reflected POLY.
  - REFLECT = 0: MSB-first, left-shifting register.
  - Fully combinational within the cycle.

Decomposition:
- Package crc_pkg holds:
  - CRC32_ETH_POLY, CRC32_ETH_RESIDUE, CRC_WIDTH = 32.
  - function crc_byte(crc, byte, poly, reflect).
  - function reflect32.
- Sub-module crc_par_update: combinational DATA_BYTES-wide update with a count input n (0..DATA_BYTES). It chains crc_byte and muxes the result by n.
- The top level holds the handshake, counters and result register.

Test Plan:
- GEN, DATA_BYTES=8, ASCII "123456789" as beats keep=0xFF then keep=0x01 with last -> res_crc=32'hCBF43926, res_len=9, res_ok=1, res_keep_err=0, one cycle after the last accept.
- CHECK, the same 9 bytes followed by FCS bytes 26 39 F4 CB (LSB of CRC first), 13 bytes across 2 beats -> res_ok=1, res_len=13. Corrupt one data bit -> res_ok=0.
- Backpressure: res_ready=0 with two back-to-back single-beat frames -> in_ready drops after the first result. The first result stays stable. Raising res_ready delivers both results in order, with no lost beat.
- keep=0b1011 single-beat last frame -> only byte 0 and byte 1 are used, res_len=2, res_keep_err=1.
- Empty frame (keep=0, last) -> res_crc=0, res_len=0. flush asserted alongside a last beat -> no res_valid.
- rst_n pulled low mid-frame -> all outputs zero asynchronously. A following "123456789" frame still gives 32'hCBF43926.
